// File: rtl/click_pkg.sv
// click_pkg: shared types and constants for the click classifier.
//   state_t   : classifier FSM state (S_TWO exists only with CLICK_TRIPLE_CLICK_EN)
//   EVT_*     : 2-bit event codes presented on evt_code_o
// Configuration macro: CLICK_TRIPLE_CLICK_EN
package click_pkg;

`ifdef CLICK_TRIPLE_CLICK_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1
    } state_t;
`endif

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_TRIPLE = 2'b11;

endpackage

// File: rtl/click_window_timer.sv
// click_window_timer: inter-press gap timer.
//   clk, rst   : clock, async active-high reset (count -> 0)
//   i_clear    : force count to 0 (has priority over i_enable)
//   i_enable   : advance count by one; saturates at WINDOW_CYCLES-1, never wraps
//   o_expire   : count has reached WINDOW_CYCLES-1
module click_window_timer #(
    parameter int WINDOW_CYCLES = 30_000_000,
    parameter int TMR_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(WINDOW_CYCLES - 1);

    logic [TMR_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expire  = w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !w_at_last)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/click_classifier.sv
// click_classifier: groups debounced press pulses into single/double/triple
// click events and hands them to a consumer through a 1-entry register.
//   clk, rst      : clock, async active-high reset
//   press_i       : single-cycle debounced press pulse
//   evt_valid_o   : an event is held for the consumer
//   evt_code_o    : 01 single, 10 double, 11 triple, 00 when not valid
//   evt_ready_i   : consumer accepts the held event
//   busy_o        : a click sequence is open
//   drop_o        : one-cycle pulse when a new event is lost to a full register
// Configuration macro: CLICK_TRIPLE_CLICK_EN (enables state TWO and triple events;
// without it a second press emits double immediately).
module click_classifier
    import click_pkg::*;
#(
    parameter int WINDOW_CYCLES = 30_000_000,
    parameter int TMR_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press_i,
    output logic       evt_valid_o,
    output logic [1:0] evt_code_o,
    input  logic       evt_ready_i,
    output logic       busy_o,
    output logic       drop_o
);

    state_t     r_state, w_next;
    logic       w_emit;
    logic [1:0] w_code;
    logic       w_expire;
    logic       w_busy;
    logic       w_tmr_clr;
    logic       r_valid;
    logic [1:0] r_code;
    logic       r_drop;

    assign w_busy = (r_state != S_IDLE);

    // Timer restarts on every press; held at 0 while idle so a new sequence
    // always starts from a clean count.
    assign w_tmr_clr = press_i || !w_busy;

    click_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .TMR_W         (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmr_clr),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // A press is checked before expiry so a press in the expiry cycle
    // continues the sequence instead of timing it out.
    always_comb begin
        w_next = r_state;
        w_emit = 1'b0;
        w_code = EVT_NONE;
        case (r_state)
            S_IDLE: begin
                if (press_i)
                    w_next = S_ONE;
            end
            S_ONE: begin
                if (press_i) begin
`ifdef CLICK_TRIPLE_CLICK_EN
                    w_next = S_TWO;
`else
                    w_next = S_IDLE;
                    w_emit = 1'b1;
                    w_code = EVT_DOUBLE;
`endif
                end else if (w_expire) begin
                    w_next = S_IDLE;
                    w_emit = 1'b1;
                    w_code = EVT_SINGLE;
                end
            end
`ifdef CLICK_TRIPLE_CLICK_EN
            S_TWO: begin
                if (press_i) begin
                    w_next = S_IDLE;
                    w_emit = 1'b1;
                    w_code = EVT_TRIPLE;
                end else if (w_expire) begin
                    w_next = S_IDLE;
                    w_emit = 1'b1;
                    w_code = EVT_DOUBLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Output register: a pending event is only replaced when it is being
    // accepted this cycle; otherwise the newcomer is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= EVT_NONE;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_emit) begin
                if (!r_valid || evt_ready_i) begin
                    r_valid <= 1'b1;
                    r_code  <= w_code;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (r_valid && evt_ready_i) begin
                r_valid <= 1'b0;
                r_code  <= EVT_NONE;
            end
        end
    end

    assign evt_valid_o = r_valid;
    assign evt_code_o  = r_code;
    assign busy_o      = w_busy;
    assign drop_o      = r_drop;

endmodule

// File: tb/tb_click_classifier.sv
// Self-checking bench for click_classifier (WINDOW_CYCLES=10). The reference
// model tracks press count and the timestamp of the last press; an event is due
// when the count hits the maximum or when WINDOW cycles pass with no press.
module tb_click_classifier;

    localparam int W = 10;
`ifdef CLICK_TRIPLE_CLICK_EN
    localparam int MAXC = 3;
`else
    localparam int MAXC = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press_i = 1'b0;
    logic       evt_ready_i = 1'b0;
    logic       evt_valid_o;
    logic [1:0] evt_code_o;
    logic       busy_o;
    logic       drop_o;

    click_classifier #(.WINDOW_CYCLES(W), .TMR_W(25)) dut (
        .clk         (clk),
        .rst         (rst),
        .press_i     (press_i),
        .evt_valid_o (evt_valid_o),
        .evt_code_o  (evt_code_o),
        .evt_ready_i (evt_ready_i),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // reference model state
    int         m_cnt  = 0;
    int         m_last = 0;
    logic       m_valid = 1'b0;
    logic [1:0] m_code  = 2'b00;
    logic       m_drop  = 1'b0;
    int         n_evt  = 0;
    int         n_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic p, input logic r);
        logic       emit;
        logic [1:0] ecode;
        cyc++;
        emit  = 1'b0;
        ecode = 2'b00;
        if (m_cnt == 0) begin
            if (p) begin
                m_cnt  = 1;
                m_last = cyc;
            end
        end else if (p) begin
            m_cnt++;
            m_last = cyc;
            if (m_cnt == MAXC) begin
                emit  = 1'b1;
                ecode = 2'(m_cnt);
                m_cnt = 0;
            end
        end else if (cyc - m_last == W) begin
            emit  = 1'b1;
            ecode = 2'(m_cnt);
            m_cnt = 0;
        end
        m_drop = 1'b0;
        if (emit) begin
            n_evt++;
            if (!m_valid || r) begin
                m_valid = 1'b1;
                m_code  = ecode;
            end else begin
                m_drop = 1'b1;
                n_drop++;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
            m_code  = 2'b00;
        end
    endtask

    task automatic compare_all();
        chk("valid", 32'(evt_valid_o), 32'(m_valid));
        chk("code",  32'(evt_code_o),  32'(m_code));
        chk("busy",  32'(busy_o),      32'(m_cnt > 0));
        chk("drop",  32'(drop_o),      32'(m_drop));
    endtask

    // drive inputs for one cycle, advance model at the edge, check after it
    task automatic step(input logic p, input logic r);
        press_i     = p;
        evt_ready_i = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, r);
    endtask

    // asynchronous reset: outputs checked before any clock edge sees rst
    task automatic do_reset();
        press_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_code",  32'(evt_code_o),  32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_drop",  32'(drop_o),      32'd0);
        m_cnt = 0; m_valid = 1'b0; m_code = 2'b00; m_drop = 1'b0;
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // first press right after reset is accepted -> single
        step(1'b1, 1'b1); idle(W + 2, 1'b1);
        // double with an in-window gap
        step(1'b1, 1'b1); idle(6, 1'b1); step(1'b1, 1'b1); idle(W + 2, 1'b1);
        // triple (double + single without the triple feature)
        step(1'b1, 1'b1); idle(6, 1'b1); step(1'b1, 1'b1); idle(7, 1'b1);
        step(1'b1, 1'b1); idle(W + 2, 1'b1);
        // second press exactly on the expiry cycle continues the sequence
        step(1'b1, 1'b1); idle(W - 1, 1'b1); step(1'b1, 1'b1); idle(W + 2, 1'b1);
        // stalled consumer: two singles, second one dropped, then accept
        step(1'b1, 1'b0); idle(W, 1'b0); step(1'b1, 1'b0); idle(W + 2, 1'b0);
        idle(3, 1'b1);
        // emit coinciding with a handshake loads the new event without a bubble
        step(1'b1, 1'b0); idle(W, 1'b0); step(1'b1, 1'b0); idle(W - 1, 1'b0);
        step(1'b0, 1'b1); idle(3, 1'b1);
        // reset mid-sequence abandons it; a later press behaves normally
        step(1'b1, 1'b1); idle(3, 1'b1);
        do_reset();
        idle(W + 5, 1'b1);
        step(1'b1, 1'b1); idle(W + 2, 1'b1);

        // randomized phases with varying press and ready densities
        for (int ph = 0; ph < 12; ph++) begin
            int pp, pr;
            pp = $urandom_range(5, 30);
            pr = $urandom_range(10, 100);
            for (int i = 0; i < 250; i++)
                step(($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < pr));
            if (ph == 6) do_reset();
        end
        idle(W + 3, 1'b1);

        chk("events_seen", 32'(n_evt > 20), 32'd1);
        chk("drops_seen",  32'(n_drop > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
